// File: rtl/memory_cycle_if.sv
// EX/MEM inputs and MEM/WB outputs of the memory stage, bundled as one port.
interface memory_cycle_if;
  logic [31:0] ALUResultM;
  logic [31:0] WriteDataM;
  logic [31:0] PCPlus4M;
  logic [4:0]  RD_M;
  logic        RegWriteM;
  logic        MemWriteM;
  logic [1:0]  ResultSrcM;

  logic [31:0] ALUResultW;
  logic [31:0] ReadDataW;
  logic [31:0] PCPlus4W;
  logic [4:0]  RD_W;
  logic        RegWriteW;
  logic [1:0]  ResultSrcW;
  logic [31:0] ResultW;
  logic [4:0]  RD_M_H;
  logic        RegWriteM_H;

  // Upstream side: drives the M-stage fields and observes the results.
  modport master (
    output ALUResultM, WriteDataM, PCPlus4M, RD_M, RegWriteM, MemWriteM, ResultSrcM,
    input  ALUResultW, ReadDataW, PCPlus4W, RD_W, RegWriteW, ResultSrcW, ResultW,
           RD_M_H, RegWriteM_H
  );

  // Memory stage itself.
  modport slave (
    input  ALUResultM, WriteDataM, PCPlus4M, RD_M, RegWriteM, MemWriteM, ResultSrcM,
    output ALUResultW, ReadDataW, PCPlus4W, RD_W, RegWriteW, ResultSrcW, ResultW,
           RD_M_H, RegWriteM_H
  );
endinterface

// File: rtl/memory_cycle.sv
// Memory stage of the 5-stage RISC-V core: data memory plus MEM/WB register.
module memory_cycle #(
  parameter int unsigned MEM_WORDS = 1024,
  parameter int unsigned ADDR_BITS = 10
) (
  input  logic           clk,
  input  logic           rst,
  memory_cycle_if.slave  bus
);

  localparam int unsigned DATA_BITS = 32;

  // Word-addressed data memory; starts at zero and is not touched by reset.
  logic [DATA_BITS-1:0] mem [MEM_WORDS] = '{default: '0};

  logic [ADDR_BITS-1:0] wordIdx;
  logic [DATA_BITS-1:0] readData;
  logic                 unusedAddrBits;

  // Byte offset and high address bits are dropped: misaligned truncates, out-of-range wraps.
  assign wordIdx        = bus.ALUResultM[ADDR_BITS+1:2];
  assign unusedAddrBits = ^{bus.ALUResultM[DATA_BITS-1:ADDR_BITS+2], bus.ALUResultM[1:0]};
  assign readData       = mem[wordIdx];

  // Full-word store; suppressed while reset is asserted.
  always_ff @(posedge clk) begin
    if (!rst && bus.MemWriteM) begin
      mem[wordIdx] <= bus.WriteDataM;
    end
  end

  // MEM/WB pipeline register; load data captures the pre-store word on a same-edge write.
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.ALUResultW <= '0;
      bus.ReadDataW  <= '0;
      bus.PCPlus4W   <= '0;
      bus.RD_W       <= '0;
      bus.RegWriteW  <= 1'b0;
      bus.ResultSrcW <= 2'b00;
    end else begin
      bus.ALUResultW <= bus.ALUResultM;
      bus.ReadDataW  <= readData;
      bus.PCPlus4W   <= bus.PCPlus4M;
      bus.RD_W       <= bus.RD_M;
      bus.RegWriteW  <= bus.RegWriteM;
      bus.ResultSrcW <= bus.ResultSrcM;
    end
  end

  // Writeback select from the W registers; reserved encoding yields zero.
  always_comb begin
    bus.ResultW = '0;
    case (bus.ResultSrcW)
      2'b00:   bus.ResultW = bus.ALUResultW;
      2'b01:   bus.ResultW = bus.ReadDataW;
      2'b10:   bus.ResultW = bus.PCPlus4W;
      default: bus.ResultW = '0;
    endcase
  end

  // Zero-latency hazard-unit view of the MEM-stage destination.
  assign bus.RD_M_H      = bus.RD_M;
  assign bus.RegWriteM_H = bus.RegWriteM;

endmodule

// File: tb/tb_memory_cycle.sv
// Scoreboard bench for memory_cycle: expected W-stage values queued at issue, checked one edge later.
module tb_memory_cycle;

  logic clk;
  logic rst;

  memory_cycle_if bus ();

  memory_cycle #(.MEM_WORDS(1024), .ADDR_BITS(10)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic [31:0] alu;
    logic [31:0] rdata;
    logic [31:0] pc4;
    logic [4:0]  rd;
    logic        regWrite;
    logic [1:0]  src;
    logic [31:0] result;
  } expT;

  expT         sbQueue[$];
  logic [31:0] refMem [1024];
  int          errors = 0;
  int          checks = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Drive one instruction into MEM, check hazard passthrough, then check the W stage after the edge.
  task automatic issue(input string tag, input logic r, input logic [31:0] alu,
                       input logic [31:0] wd, input logic [31:0] pc4, input logic [4:0] rd,
                       input logic rw, input logic mw, input logic [1:0] src);
    expT e;
    int  idx;
    rst            = r;
    bus.ALUResultM = alu;
    bus.WriteDataM = wd;
    bus.PCPlus4M   = pc4;
    bus.RD_M       = rd;
    bus.RegWriteM  = rw;
    bus.MemWriteM  = mw;
    bus.ResultSrcM = src;

    idx   = int'(alu[11:2]);
    e.tag = tag;
    if (r) begin
      e.alu = '0; e.rdata = '0; e.pc4 = '0; e.rd = '0; e.regWrite = 1'b0; e.src = 2'b00;
    end else begin
      e.alu = alu; e.rdata = refMem[idx]; e.pc4 = pc4; e.rd = rd; e.regWrite = rw; e.src = src;
      if (mw) refMem[idx] = wd;
    end
    case (e.src)
      2'b00:   e.result = e.alu;
      2'b01:   e.result = e.rdata;
      2'b10:   e.result = e.pc4;
      default: e.result = 32'd0;
    endcase
    sbQueue.push_back(e);

    #1;
    check({tag, ".rdH"}, 32'(bus.RD_M_H), 32'(rd));
    check({tag, ".rwH"}, 32'(bus.RegWriteM_H), 32'(rw));

    @(posedge clk);
    #1;
    if (sbQueue.size() == 0) begin
      check({tag, ".sbEmpty"}, 32'd0, 32'd1);
    end else begin
      e = sbQueue.pop_front();
      check({e.tag, ".aluW"}, bus.ALUResultW, e.alu);
      check({e.tag, ".readW"}, bus.ReadDataW, e.rdata);
      check({e.tag, ".pc4W"}, bus.PCPlus4W, e.pc4);
      check({e.tag, ".rdW"}, 32'(bus.RD_W), 32'(e.rd));
      check({e.tag, ".rwW"}, 32'(bus.RegWriteW), 32'(e.regWrite));
      check({e.tag, ".srcW"}, 32'(bus.ResultSrcW), 32'(e.src));
      check({e.tag, ".result"}, bus.ResultW, e.result);
    end
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) refMem[i] = 32'd0;
    rst            = 1'b1;
    bus.ALUResultM = '0;
    bus.WriteDataM = '0;
    bus.PCPlus4M   = '0;
    bus.RD_M       = '0;
    bus.RegWriteM  = 1'b0;
    bus.MemWriteM  = 1'b0;
    bus.ResultSrcM = 2'b00;

    // Reset with a store in flight: outputs zero, store dropped.
    issue("rst0", 1'b1, 32'h10, 32'hDEADBEEF, 32'h4, 5'd3, 1'b1, 1'b1, 2'b01);
    issue("rst1", 1'b1, 32'h10, 32'hDEADBEEF, 32'h4, 5'd3, 1'b1, 1'b1, 2'b01);
    check("rst.resultLit", bus.ResultW, 32'd0);
    issue("ldRst", 1'b0, 32'h10, 32'h0, 32'h8, 5'd1, 1'b1, 1'b0, 2'b01);
    check("ldRst.lit", bus.ReadDataW, 32'd0);

    // Store then back-to-back load.
    issue("st40", 1'b0, 32'h40, 32'hCAFEF00D, 32'h100, 5'd0, 1'b0, 1'b1, 2'b00);
    issue("ld40", 1'b0, 32'h40, 32'h0, 32'h104, 5'd5, 1'b1, 1'b0, 2'b01);
    check("ld40.readLit", bus.ReadDataW, 32'hCAFEF00D);
    check("ld40.resLit", bus.ResultW, 32'hCAFEF00D);
    check("ld40.rdLit", 32'(bus.RD_W), 32'd5);

    // Read during write returns the old word; the next load sees the new one.
    issue("st8", 1'b0, 32'h8, 32'h11111111, 32'h108, 5'd0, 1'b0, 1'b1, 2'b00);
    issue("rdw8", 1'b0, 32'h8, 32'h22222222, 32'h10C, 5'd6, 1'b1, 1'b1, 2'b01);
    check("rdw8.oldLit", bus.ReadDataW, 32'h11111111);
    issue("ld8", 1'b0, 32'h8, 32'h0, 32'h110, 5'd6, 1'b1, 1'b0, 2'b01);
    check("ld8.newLit", bus.ReadDataW, 32'h22222222);

    // Wrap and misalignment.
    issue("stWrap", 1'b0, 32'h1003, 32'hA5A5A5A5, 32'h114, 5'd0, 1'b0, 1'b1, 2'b00);
    issue("ld0", 1'b0, 32'h0, 32'h0, 32'h118, 5'd8, 1'b1, 1'b0, 2'b01);
    check("ld0.lit", bus.ResultW, 32'hA5A5A5A5);
    issue("ld1001", 1'b0, 32'h1001, 32'h0, 32'h11C, 5'd9, 1'b1, 1'b0, 2'b01);
    check("ld1001.lit", bus.ResultW, 32'hA5A5A5A5);

    // Result select steps, including a passed-through x0 write.
    issue("selAlu", 1'b0, 32'h123, 32'h0, 32'h204, 5'd0, 1'b1, 1'b0, 2'b00);
    check("selAlu.lit", bus.ResultW, 32'h123);
    issue("selPc", 1'b0, 32'h123, 32'h0, 32'h204, 5'd10, 1'b1, 1'b0, 2'b10);
    check("selPc.lit", bus.ResultW, 32'h204);
    issue("selRsv", 1'b0, 32'h123, 32'h0, 32'h204, 5'd11, 1'b1, 1'b0, 2'b11);
    check("selRsv.lit", bus.ResultW, 32'h0);

    // Hazard passthrough and mid-stream reset.
    issue("hz7", 1'b0, 32'h40, 32'h0, 32'h300, 5'd7, 1'b1, 1'b0, 2'b01);
    issue("midRst", 1'b1, 32'h40, 32'h0, 32'h304, 5'd7, 1'b1, 1'b0, 2'b01);
    check("midRst.rwLit", 32'(bus.RegWriteW), 32'd0);
    issue("resume", 1'b0, 32'h40, 32'h0, 32'h308, 5'd7, 1'b1, 1'b0, 2'b01);
    check("resume.lit", bus.ResultW, 32'hCAFEF00D);

    // A few randomized store/load pairs over a small address window.
    for (int i = 0; i < 8; i++) begin
      logic [31:0] a;
      logic [31:0] d;
      a = 32'($urandom_range(0, 63)) << 2;
      d = $urandom;
      issue("rndSt", 1'b0, a, d, 32'h400, 5'd0, 1'b0, 1'b1, 2'b00);
      issue("rndLd", 1'b0, a, 32'h0, 32'h404, 5'(i + 12), 1'b1, 1'b0, 2'b01);
      check("rndLd.data", bus.ResultW, d);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/memory_cycle.md
Name: memory_cycle

Overview:
- Memory stage of the 5-stage RISC-V core; consumes the EX/MEM outputs of the execute stage.
- Performs data-memory store/load and holds the MEM/WB pipeline register.
- Produces the writeback result ResultW, which feeds back to the execute-stage forwarding muxes.
- Exports the MEM-stage destination and write-enable to the hazard unit.

Parameters:
- MEM_WORDS, 1024, depth of data memory in 32-bit words (power of two).
- ADDR_BITS, 10, log2(MEM_WORDS); word index width.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- ALUResultM  input  32  ALU result from EX/MEM; byte address for loads/stores.
- WriteDataM  input  32  store data (already forwarded in execute).
- PCPlus4M  input  32  PC+4 of the instruction in MEM.
- RD_M  input  5  destination register.
- RegWriteM  input  1  register-write enable.
- MemWriteM  input  1  data-memory write enable.
- ResultSrcM  input  2  result select: 00 ALU, 01 memory, 10 PC+4, 11 reserved.
- ALUResultW  output  32  registered ALU result.
- ReadDataW  output  32  registered load data.
- PCPlus4W  output  32  registered PC+4.
- RD_W  output  5  registered destination register.
- RegWriteW  output  1  registered write enable.
- ResultSrcW  output  2  registered result select.
- ResultW  output  32  writeback value (combinational from W registers).
- RD_M_H  output  5  RD_M passthrough to hazard unit.
- RegWriteM_H  output  1  RegWriteM passthrough to hazard unit.

Behaviour:
- Memory array:
  - MEM_WORDS x 32 bits, zero at time 0. Reset does not clear it.
  - Word index = ALUResultM[ADDR_BITS+1:2]; bits [1:0] and bits above ADDR_BITS+1 are ignored (misaligned addresses truncate, out-of-range addresses wrap).
- Store:
  - On a rising edge with rst=0 and MemWriteM=1, mem[index] <= WriteDataM. Full word only.
  - Stores are suppressed while rst=1, including a store already in flight at the reset edge.
- Load read:
  - Combinational from mem[index], captured into ReadDataW at the same edge.
  - Latency: a load in MEM at cycle n gives ReadDataW valid in cycle n+1.
- Read-during-write, same index, same edge: ReadDataW captures the OLD word; the new word is visible to any later access.
- MEM/WB register (every edge):
  - rst=1: ALUResultW, ReadDataW, PCPlus4W = 0; RD_W = 0; RegWriteW = 0; ResultSrcW = 00. ResultW is therefore 0.
  - rst=0: all W registers load their M-side counterparts. There is no enable or stall; the stage always advances.
- ResultW:
  - ResultSrcW=00 gives ALUResultW; 01 gives ReadDataW; 10 gives PCPlus4W; 11 gives 32'd0.
  - Purely combinational; no extra cycle.
- RD_M_H = RD_M and RegWriteM_H = RegWriteM, combinational with zero latency; they are not affected by reset.
- A write to x0 is not filtered here: RD_W=0 with RegWriteW=1 is passed through, and the register file ignores it.
- Back-to-back store then load to the same address in consecutive cycles: the load returns the stored value.
- No X may propagate to any output after the first reset edge.

Test Plan:
- Reset: hold rst=1 for 2 cycles with MemWriteM=1, ALUResultM=0x10, WriteDataM=0xDEADBEEF -> all W outputs 0, ResultW=0; then load 0x10 -> ReadDataW=0 (store suppressed).
- Store/load:
  - Store 0xCAFEF00D to 0x40.
  - Next cycle, load 0x40 with ResultSrcM=01, RD_M=5, RegWriteM=1 -> one cycle later ReadDataW=ResultW=0xCAFEF00D, RD_W=5, RegWriteW=1.
- Read-during-write: mem[0x8]=0x11111111; same cycle, MemWriteM=1 with WriteDataM=0x22222222 at 0x8 and ResultSrcM=01 -> ReadDataW=0x11111111; a following load returns 0x22222222.
- Address wrap/misalign (MEM_WORDS=1024):
  - Store 0xA5A5A5A5 at 0x1003 -> a load at 0x0000 returns 0xA5A5A5A5.
  - A load at 0x1001 also returns 0xA5A5A5A5.
- ResultSrc select: ALUResultM=0x123, PCPlus4M=0x204, with ResultSrcM stepped through 00/10/11 -> ResultW=0x123 / 0x204 / 0x0, each one cycle after issue.
- Hazard passthrough and mid-stream reset:
  - RD_M=7, RegWriteM=1 -> RD_M_H=7, RegWriteM_H=1 in the same cycle.
  - Assert rst for one cycle mid-stream -> the next cycle shows RegWriteW=0, RD_W=0.
  - The pipeline resumes loading on the following edge.
